// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// - md_op_t      : 4-bit opcode presented with start
// - is_long_op() : op occupies the unit for a multi-cycle latency
// - is_div_op()  : op uses the divide latency
// - is_signed_op(): operands are treated as two's complement
package md_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MADD  = 4'd7,
    MADDU = 4'd8,
    MSUB  = 4'd9,
    MSUBU = 4'd10
  } md_op_t;

  function automatic logic is_long_op(md_op_t op);
    case (op)
      MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(md_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed_op(md_op_t op);
    return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
  endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// E-stage request/response bundle for the multiply/divide unit.
// master (E stage): start, op, a, b, flush -> ; <- busy, hi, lo
// slave  (md unit): the reverse.
interface md_unit_param_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, hi, lo);

endinterface

// File: rtl/md_latency_ctr.sv
// Latency down-counter shared by the multiply and divide paths.
// Ports: clk, reset (sync, active high), load/load_val (start a new
// latency), dec (count down while running), clear (abort), zero (terminal
// count reached).
module md_latency_ctr #(
  parameter int MAXLAT = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [$clog2(MAXLAT+1)-1:0]   load_val,
  input  logic                          dec,
  input  logic                          clear,
  output logic                          zero
);

  localparam int CW = $clog2(MAXLAT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with architectural HI/LO.
// Ports: clk, reset (sync, active high), bus (slave side of
// md_unit_param_if: start/op/a/b/flush in, busy/hi/lo out).
// The result is computed in the capture cycle; the counter only models
// the busy latency before the result is committed to HI/LO.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no long op in flight; MTHI/MTLO and new long ops accepted
// RUN   | long op in flight; result held in pend_*, busy asserted
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  md_unit_param_if.slave    bus
);

  localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q, lo_q, pend_hi, pend_lo;
  logic               accept, ctr_zero;
  logic               sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, result;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;

  assign accept = (state == IDLE) && bus.start && !bus.flush;

  // Signed MIN / -1 needs no special case: |MIN| is 2^(WIDTH-1) as an
  // unsigned magnitude, so the quotient comes out as MIN with remainder 0.
  always_comb begin
    sgn   = is_signed_op(bus.op);
    a_ext = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    b_ext = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    quo   = '0;
    rem   = '0;
    if (bus.b != '0) begin
      quo = mag_a / mag_b;
      rem = mag_a % mag_b;
      if (sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])) quo = -quo;
      if (sgn && bus.a[WIDTH-1]) rem = -rem;
    end
    case (bus.op)
      MULT, MULTU: result = prod;
      MADD, MADDU: result = acc + prod;
      MSUB, MSUBU: result = acc - prod;
      DIV, DIVU:   result = (bus.b == '0) ? acc : {rem, quo};
      default:     result = acc;
    endcase
  end

  md_latency_ctr #(.MAXLAT(MAXLAT)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && is_long_op(bus.op)),
    .load_val (is_div_op(bus.op) ? DIV_LOAD : MULT_LOAD),
    .dec      (state == RUN),
    .clear    ((state == RUN) && bus.flush),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_long_op(bus.op)) begin
              {pend_hi, pend_lo} <= result;
              busy_q             <= 1'b1;
              state              <= RUN;
            end else if (bus.op == MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        RUN: begin
          // Flush wins over a same-cycle commit: a squashed op never lands.
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (ctr_zero) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
module tb_md_unit_param;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_param_if #(.WIDTH(32)) b32 ();
  md_unit_param_if #(.WIDTH(8))  b8 ();

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave));
  md_unit_param #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave));

  typedef struct {
    bit          snap;   // 1: compare at cycle 'due'; 0: compare when busy falls
    int          due;
    logic [63:0] hilo;
    int          len;
    int          op;
    int          seq;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int seq = 0;
  bit pb[2];
  int bl[2];
  longint unsigned rhilo[2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    assert (!(b32.start === 1'b1 && b32.busy === 1'b1 && b32.flush !== 1'b1))
      else $error("FAIL protocol: start while busy on dut32");
    assert (!(b8.start === 1'b1 && b8.busy === 1'b1 && b8.flush !== 1'b1))
      else $error("FAIL protocol: start while busy on dut8");
  end

  // ---------------- reference model ----------------
  function automatic longint unsigned mask_w(int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sx(longint unsigned x, int w);
    return x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
  endfunction

  // Returns the new HI:LO (HI in bits [2w-1:w]) after op, per the ISA rules.
  function automatic longint unsigned model(int w, md_op_t op, longint unsigned a_in,
                                            longint unsigned b_in, longint unsigned hl);
    longint unsigned m1, m2, a, b, hi, lo, prod, res;
    longint sq, sr;
    m1 = mask_w(w);
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((longint'(1) << (2*w)) - 1);
    a = a_in & m1;
    b = b_in & m1;
    hi = (hl >> w) & m1;
    lo = hl & m1;
    if (op == MULT || op == MADD || op == MSUB) prod = longint'(sx(a, w) * sx(b, w));
    else prod = a * b;
    res = hl;
    case (op)
      MULT, MULTU: res = prod;
      MADD, MADDU: res = hl + prod;
      MSUB, MSUBU: res = hl - prod;
      DIV: if (b != 0) begin
        sq = sx(a, w) / sx(b, w);
        sr = sx(a, w) % sx(b, w);
        res = ((longint'(sr) & m1) << w) | (longint'(sq) & m1);
      end
      DIVU: if (b != 0) res = ((a % b) << w) | (a / b);
      MTHI: res = (a << w) | lo;
      MTLO: res = (hi << w) | a;
      default: res = hl;
    endcase
    return res & m2;
  endfunction

  function automatic int lat_of(bit s, md_op_t op);
    if (!is_long_op(op)) return 0;
    if (op == DIV || op == DIVU) return s ? 3 : 10;
    return s ? 1 : 5;
  endfunction

  // ---------------- scoreboard helpers ----------------
  function automatic void push(bit s, exp_t e);
    if (s) q8.push_back(e); else q32.push_back(e);
  endfunction
  function automatic int qsz(bit s);
    return s ? q8.size() : q32.size();
  endfunction
  function automatic exp_t qfront(bit s);
    return s ? q8[0] : q32[0];
  endfunction
  function automatic exp_t qpop(bit s);
    return s ? q8.pop_front() : q32.pop_front();
  endfunction

  function automatic void chk(string name, bit s, int sq, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d op#%0d: got 0x%0h expected 0x%0h", name, s ? 8 : 32, sq, act, exp);
    end
  endfunction

  function automatic void mon(bit s);
    logic [63:0] hl;
    logic bz;
    exp_t e;
    hl = s ? {48'b0, b8.hi, b8.lo} : {b32.hi, b32.lo};
    bz = s ? b8.busy : b32.busy;
    if (qsz(s) > 0 && qfront(s).snap && qfront(s).due == cyc) begin
      e = qpop(s);
      chk("snap_hilo", s, e.seq, hl, e.hilo);
      chk("snap_busy", s, e.seq, {63'b0, bz}, 64'd0);
    end
    if (pb[s] && bz !== 1'b1) begin
      if (qsz(s) > 0 && !qfront(s).snap) begin
        e = qpop(s);
        chk("long_hilo", s, e.seq, hl, e.hilo);
        chk("busy_len", s, e.seq, 64'(bl[s]), 64'(e.len));
      end else begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_busy_fall dut%0d: got busy run %0d expected none", s ? 8 : 32, bl[s]);
      end
    end
    if (bz === 1'b1) bl[s] = pb[s] ? bl[s] + 1 : 1;
    pb[s] = (bz === 1'b1);
  endfunction

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  // ---------------- driver ----------------
  task automatic drive(bit s, logic st, md_op_t op, longint unsigned a, longint unsigned b, logic fl);
    if (s) begin
      b8.start = st; b8.op = op; b8.a = a[7:0]; b8.b = b[7:0]; b8.flush = fl;
    end else begin
      b32.start = st; b32.op = op; b32.a = a[31:0]; b32.b = b[31:0]; b32.flush = fl;
    end
  endtask

  task automatic do_op(bit s, md_op_t op, longint unsigned a, longint unsigned b,
                       int abort_at, bit use_reset, bit start_flush);
    int w, lat, n;
    longint unsigned res;
    exp_t e;
    w = s ? 8 : 32;
    lat = lat_of(s, op);
    @(negedge clk);
    drive(s, 1'b1, op, a, b, start_flush);
    seq++;
    e.op = int'(op);
    e.seq = seq;
    e.len = 0;
    if (start_flush || lat == 0) begin
      if (!start_flush) rhilo[s] = model(w, op, a, b, rhilo[s]);
      e.snap = 1'b1;
      e.due = cyc + 1;
      e.hilo = rhilo[s];
      push(s, e);
      @(negedge clk);
      drive(s, 1'b0, NOP, 0, 0, 1'b0);
      return;
    end
    res = model(w, op, a, b, rhilo[s]);
    if (abort_at > 0) begin
      if (use_reset) begin
        res = 0;
        rhilo[0] = 0;
        rhilo[1] = 0;
      end else begin
        res = rhilo[s];
      end
    end
    rhilo[s] = res;
    e.snap = 1'b0;
    e.due = 0;
    e.hilo = res;
    e.len = (abort_at > 0) ? abort_at : lat;
    push(s, e);
    @(negedge clk);
    drive(s, 1'b0, NOP, 0, 0, 1'b0);
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      if (use_reset) reset = 1'b1;
      else drive(s, 1'b0, NOP, 0, 0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      drive(s, 1'b0, NOP, 0, 0, 1'b0);
    end
    n = 0;
    while (((s ? b8.busy : b32.busy) === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", s, seq, 64'(n >= 40), 64'd0);
  endtask

  function automatic longint unsigned pick(int w);
    case ($urandom_range(0, 5))
      0: return 0;
      1: return mask_w(w);
      2: return longint'(1) << (w - 1);
      3: return 1;
      default: return {$urandom, $urandom} & mask_w(w);
    endcase
  endfunction

  task automatic random_ops(bit s, int count);
    md_op_t op;
    int ab;
    for (int i = 0; i < count; i++) begin
      op = md_op_t'(4'($urandom_range(0, 10)));
      ab = 0;
      if (is_long_op(op) && $urandom_range(0, 7) == 0) ab = $urandom_range(1, lat_of(s, op));
      do_op(s, op, pick(s ? 8 : 32), pick(s ? 8 : 32), ab, 1'b0, ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    drive(1'b0, 1'b0, NOP, 0, 0, 1'b0);
    drive(1'b1, 1'b0, NOP, 0, 0, 1'b0);
    rhilo[0] = 0;
    rhilo[1] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    e.snap = 1'b1; e.due = cyc + 1; e.hilo = 0; e.len = 0; e.op = 0; e.seq = 0;
    push(1'b0, e);
    push(1'b1, e);

    do_op(0, MULT,  64'hFFFF_FFFD, 7, 0, 0, 0);
    do_op(0, MULTU, 64'hFFFF_FFFF, 2, 0, 0, 0);
    do_op(0, MADDU, 1, 1, 0, 0, 0);
    do_op(0, DIV,   64'hFFFF_FFF9, 2, 0, 0, 0);
    do_op(0, DIV,   1234, 0, 0, 0, 0);
    do_op(0, MTHI,  64'h1234, 0, 0, 0, 0);
    do_op(0, DIV,   100, 7, 4, 0, 0);
    do_op(0, MULT,  5, 6, 2, 1, 0);
    do_op(0, MTLO,  64'h55, 0, 0, 0, 1);
    do_op(0, DIV,   9, 2, 0, 0, 1);
    do_op(0, MTLO,  64'hABCD, 0, 0, 0, 0);
    do_op(0, MSUB,  3, 64'hFFFF_FFFE, 0, 0, 0);
    do_op(0, MADD,  64'h8000_0000, 64'h8000_0000, 0, 0, 0);
    do_op(0, DIV,   64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0);
    do_op(0, DIVU,  64'hFFFF_FFFF, 10, 0, 0, 0);
    do_op(0, MSUBU, 7, 9, 5, 0, 0);
    random_ops(0, 60);

    do_op(1, MULT,  64'h80, 64'h80, 0, 0, 0);
    do_op(1, DIV,   64'h80, 64'hFF, 0, 0, 0);
    do_op(1, MADDU, 64'hFF, 64'hFF, 1, 0, 0);
    random_ops(1, 40);

    repeat (3) @(negedge clk);
    chk("q32_drained", 1'b0, seq, 64'(q32.size()), 64'd0);
    chk("q8_drained", 1'b1, seq, 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
